// File: rtl/turbo_deintlv_buf.sv
// -----------------------------------------------------------------------------
// turbo_deintlv_buf
//
// Receive-side turbo deinterleaver buffer. Soft samples y[k] arrive in
// interleaved order. Each one is written to mem[pi(k)], where pi(k) comes from
// the external interleaver ROM. The frame is then read back in natural order.
//
// Optional feature: define DEINTLV_BYPASS_EN to add the cfg_bypass input.
// When cfg_bypass is latched as 1 on start, sample k is written to mem[k] and
// the ROM output is ignored.
//
// Ports
//   clk, n_rst      clock, asynchronous active-low reset
//   start           1-cycle pulse; latches cfg_len/cfg_jump(/cfg_bypass)
//   cfg_len         frame length, 1 .. 2**DEPTH_LOG2
//   cfg_jump        link-id base offset into the ROM
//   cfg_bypass      (DEINTLV_BYPASS_EN only) write in natural order
//   in_valid/in_ready/in_data         interleaved input stream
//   rom_waddr/rom_jump                ROM address (k, offset)
//   rom_itl_addr                      pi(k), valid 1 cycle after rom_waddr
//   out_valid/out_ready/out_data/out_last  deinterleaved output stream
//   busy            high in any state other than IDLE
//   done            1-cycle pulse after the last output handshake
//   err_cfg         1-cycle pulse when a start is rejected
//   err_range       sticky: pi(k) >= len was seen in this frame
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module turbo_deintlv_buf #(
  parameter int D_WIDTH    = 6,
  parameter int A_WIDTH    = 16,
  parameter int DEPTH_LOG2 = 13
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [15:0]        cfg_len,
  input  logic [A_WIDTH-1:0] cfg_jump,
`ifdef DEINTLV_BYPASS_EN
  input  logic               cfg_bypass,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic [A_WIDTH-1:0] rom_waddr,
  output logic [A_WIDTH-1:0] rom_jump,
  input  logic [A_WIDTH-1:0] rom_itl_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err_cfg,
  output logic               err_range
);

  // Counters are one bit wider than the RAM index so that a full-size frame
  // (len = 2**DEPTH_LOG2) can be counted without wrap-around.
  localparam int          CW      = DEPTH_LOG2 + 1;
  localparam int unsigned MAX_LEN = 32'd1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        len_q, len_d;
  logic [A_WIDTH-1:0]   jump_q, jump_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
  logic                 wr_pend_q, wr_pend_d;
  logic [D_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 err_cfg_q, err_cfg_d;
  logic                 err_range_q, err_range_d;
  logic [D_WIDTH-1:0]   out_data_q;

  logic                 mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic                 rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [A_WIDTH-1:0]   wr_tgt;   // full-width write target, used for range check
  logic [A_WIDTH-1:0]   len_ext;
  logic                 len_ok;

  logic [D_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

  assign len_ext = {{(A_WIDTH-CW){1'b0}}, len_q};
  assign len_ok  = (cfg_len != 16'd0) && (32'(cfg_len) <= MAX_LEN);
  assign rd_addr = rd_cnt_q[DEPTH_LOG2-1:0];

`ifdef DEINTLV_BYPASS_EN
  logic          bypass_q, bypass_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;   // k of the delayed write, used in bypass

  assign wr_tgt    = bypass_q ? {{(A_WIDTH-CW){1'b0}}, wr_idx_q} : rom_itl_addr;
  assign mem_waddr = bypass_q ? wr_idx_q[DEPTH_LOG2-1:0]
                              : rom_itl_addr[DEPTH_LOG2-1:0];
`else
  assign wr_tgt    = rom_itl_addr;
  assign mem_waddr = rom_itl_addr[DEPTH_LOG2-1:0];
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_d     = state_q;
    len_d       = len_q;
    jump_d      = jump_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_pend_d   = 1'b0;
    wr_data_d   = wr_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_cfg_d   = 1'b0;
    err_range_d = err_range_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
`ifdef DEINTLV_BYPASS_EN
    bypass_d    = bypass_q;
    wr_idx_d    = wr_idx_q;
`endif

    // Delayed write: the sample accepted last cycle meets its ROM address now.
    if (wr_pend_q) begin
      if (wr_tgt < len_ext) mem_we = 1'b1;
      else                  err_range_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d       = cfg_len[CW-1:0];
            jump_d      = cfg_jump;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            err_range_d = 1'b0;
            state_d     = ST_FILL;
`ifdef DEINTLV_BYPASS_EN
            bypass_d    = cfg_bypass;
`endif
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if (in_valid && in_ready_q) begin
          wr_pend_d = 1'b1;
          wr_data_d = in_data;
          wr_cnt_d  = wr_cnt_q + CW'(1);
`ifdef DEINTLV_BYPASS_EN
          wr_idx_d  = wr_cnt_q;
`endif
          if (wr_cnt_q + CW'(1) == len_q) state_d = ST_FLUSH;
        end
      end

      // One cycle for the final delayed write to land before reading.
      ST_FLUSH: state_d = ST_DRAIN;

      ST_DRAIN: begin
        if ((rd_cnt_q < len_q) && (!out_valid_q || out_ready)) begin
          rd_en       = 1'b1;
          rd_cnt_d    = rd_cnt_q + CW'(1);
          out_valid_d = 1'b1;
          out_last_d  = (rd_cnt_q + CW'(1) == len_q);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (out_valid_q && out_ready && out_last_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    in_ready_d = (state_d == ST_FILL) && (wr_cnt_d < len_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      jump_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_range_q <= 1'b0;
`ifdef DEINTLV_BYPASS_EN
      bypass_q    <= 1'b0;
      wr_idx_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      jump_q      <= jump_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_pend_q   <= wr_pend_d;
      wr_data_q   <= wr_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_cfg_q   <= err_cfg_d;
      err_range_q <= err_range_d;
`ifdef DEINTLV_BYPASS_EN
      bypass_q    <= bypass_d;
      wr_idx_q    <= wr_idx_d;
`endif
    end
  end

  // NOTE: the sample array has no reset; it is always written before it is
  // read in a frame, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wr_data_q;
  end

  // RAM output register; it doubles as out_data and only advances on a read,
  // which holds the sample stable while the consumer stalls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     out_data_q <= '0;
    else if (rd_en) out_data_q <= mem[rd_addr];
  end

  assign in_ready  = in_ready_q;
  assign rom_waddr = {{(A_WIDTH-CW){1'b0}}, wr_cnt_q};
  assign rom_jump  = jump_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cfg   = err_cfg_q;
  assign err_range = err_range_q;

endmodule

// File: tb/tb_turbo_deintlv_buf.sv
// -----------------------------------------------------------------------------
// tb_turbo_deintlv_buf
//
// Scoreboard bench for turbo_deintlv_buf. Stimulus pushes hand-computed
// expected outputs into a queue; a negedge monitor pops and compares on every
// output handshake and checks that stalled outputs stay stable. A registered
// ROM model returns rom_tab[rom_waddr + rom_jump] one clock later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_turbo_deintlv_buf;

  localparam int DW = 6;
  localparam int AW = 16;
  localparam int DL = 13;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cfg_len = '0;
  logic [AW-1:0] cfg_jump = '0;
`ifdef DEINTLV_BYPASS_EN
  logic          cfg_bypass = 1'b0;
`endif
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] rom_waddr;
  logic [AW-1:0] rom_jump;
  logic [AW-1:0] rom_itl_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy, done, err_cfg, err_range;

  turbo_deintlv_buf #(.D_WIDTH(DW), .A_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .cfg_len      (cfg_len),
    .cfg_jump     (cfg_jump),
`ifdef DEINTLV_BYPASS_EN
    .cfg_bypass   (cfg_bypass),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .rom_waddr    (rom_waddr),
    .rom_jump     (rom_jump),
    .rom_itl_addr (rom_itl_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err_cfg      (err_cfg),
    .err_range    (err_range)
  );

  always #5 clk = ~clk;

  // ROM model
  logic [AW-1:0] rom_tab [0:(1<<DL)-1];
  logic [DL-1:0] rom_idx;
  assign rom_idx = DL'(rom_waddr + rom_jump);
  always @(posedge clk) rom_itl_addr <= rom_tab[rom_idx];

  // Scoreboard
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          care;   // 0: RAM location was never written this frame
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_hs_cyc = -10;
  bit   toggle_rdy = 1'b0;

  logic          held_v = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic          held_l = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = toggle_rdy ? ~out_ready : 1'b1;
  end

  // Monitor
  always @(negedge clk) begin
    if (n_rst) begin
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'(1'b1));
        check("hold_data",  32'(out_data),  32'(held_d));
        check("hold_last",  32'(out_last),  32'(held_l));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.care) check("out_data", 32'(out_data), 32'(mon_e.data));
          check("out_last", 32'(out_last), 32'(mon_e.last));
          if (out_last) last_hs_cyc = cyc;
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end else begin
      held_v = 1'b0;
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input int jump);
    cfg_len  = 16'(len);
    cfg_jump = AW'(jump);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic push_exp(input int data, input bit last, input bit care);
    exp_t e;
    e.data = DW'(data);
    e.last = last;
    e.care = care;
    sb.push_back(e);
  endtask

  task automatic push_list(input int vals [8]);
    for (int i = 0; i < 8; i++) push_exp(vals[i], i == 7, 1'b1);
  endtask

  task automatic load_pi(input int base);
    int pi [8] = '{3, 0, 6, 1, 7, 2, 4, 5};
    for (int k = 0; k < 8; k++) rom_tab[base + k] = AW'(pi[k]);
  endtask

  // Called at #1 after a posedge; returns at #1 after the last handshake edge.
  task automatic send(input int n, input int base, input bit gaps);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 2 == 1)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = DW'(base + k);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        fail_now("in_ready_timeout");
        in_valid = 1'b0;
        tick();
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    @(negedge clk);
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done), 32'(1'b1));
    if (done) begin
      check("done_after_last", 32'(cyc), 32'(last_hs_cyc + 1));
      check("busy_after_done", 32'(busy), 32'(1'b0));
    end
    check("sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);
    check("done_pulse_1cyc", 32'(done), 32'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << DL); i++) rom_tab[i] = AW'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_out_last",  32'(out_last),  32'(0));
    check("rst_done",      32'(done),      32'(0));
    check("rst_err_cfg",   32'(err_cfg),   32'(0));
    check("rst_err_range", 32'(err_range), 32'(0));
    check("rst_rom_waddr", 32'(rom_waddr), 32'(0));
    check("rst_rom_jump",  32'(rom_jump),  32'(0));
    n_rst = 1'b1;
    tick();

    // 1: basic deinterleave, back-to-back input, jump = 0
    load_pi(0);
    push_list('{11, 13, 15, 10, 16, 17, 12, 14});
    do_start(8, 0);
    check("t1_busy", 32'(busy), 32'(1));
    check("t1_in_ready", 32'(in_ready), 32'(1));
    send(8, 10, 1'b0);
    wait_done(100);
    check("t1_err_range", 32'(err_range), 32'(0));

    // 2: same with jump = 100, 50% in_valid, toggling out_ready
    load_pi(100);
    toggle_rdy = 1'b1;
    push_list('{11, 13, 15, 10, 16, 17, 12, 14});
    do_start(8, 100);
    check("t2_rom_jump", 32'(rom_jump), 32'(100));
    send(8, 10, 1'b1);
    // start while busy is ignored
    cfg_len = 16'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t2_busy_start_no_err", 32'(err_cfg), 32'(0));
    check("t2_busy_still", 32'(busy), 32'(1));
    wait_done(200);
    toggle_rdy = 1'b0;

    // 4: out-of-range pi(2) = 9 suppresses that write; frame completes
    rom_tab[2] = AW'(9);
    push_exp(21, 1'b0, 1'b1);
    push_exp(23, 1'b0, 1'b1);
    push_exp(25, 1'b0, 1'b1);
    push_exp(20, 1'b0, 1'b1);
    push_exp(26, 1'b0, 1'b1);
    push_exp(27, 1'b0, 1'b1);
    push_exp(0,  1'b0, 1'b0);
    push_exp(24, 1'b1, 1'b1);
    do_start(8, 0);
    send(8, 20, 1'b0);
    wait_done(100);
    check("t4_err_range_set", 32'(err_range), 32'(1));
    rom_tab[2] = AW'(6);

    // 3: illegal lengths
    do_start(0, 0);
    check("t3_len0_err_cfg", 32'(err_cfg), 32'(1));
    check("t3_len0_busy", 32'(busy), 32'(0));
    check("t3_err_range_kept", 32'(err_range), 32'(1));
    tick();
    check("t3_err_cfg_pulse", 32'(err_cfg), 32'(0));
    do_start(8193, 0);
    check("t3_len8193_err_cfg", 32'(err_cfg), 32'(1));
    check("t3_len8193_busy", 32'(busy), 32'(0));
    tick();

    // 3: maximum length with identity ROM
    for (int i = 0; i < (1 << DL); i++) rom_tab[i] = AW'(i);
    for (int i = 0; i < (1 << DL); i++) push_exp(i % 64, i == (1 << DL) - 1, 1'b1);
    do_start(8192, 0);
    check("t3_err_range_cleared", 32'(err_range), 32'(0));
    check("t3_err_cfg_valid", 32'(err_cfg), 32'(0));
    send(8192, 0, 1'b0);
    wait_done(20000);

    // 5: reset mid-FILL at k = 4
    load_pi(0);
    do_start(8, 0);
    send(4, 10, 1'b0);
    in_valid = 1'b1;
    in_data  = DW'(14);
    n_rst    = 1'b0;
    #1;
    check("t5_in_ready_rst", 32'(in_ready), 32'(0));
    check("t5_busy_rst", 32'(busy), 32'(0));
    check("t5_rom_waddr_rst", 32'(rom_waddr), 32'(0));
    tick();
    in_valid = 1'b0;
    n_rst    = 1'b1;
    tick();
    push_list('{11, 13, 15, 10, 16, 17, 12, 14});
    do_start(8, 0);
    send(8, 10, 1'b0);
    wait_done(100);

`ifdef DEINTLV_BYPASS_EN
    // 6: bypass writes in natural order
    cfg_bypass = 1'b1;
    push_list('{10, 11, 12, 13, 14, 15, 16, 17});
    do_start(8, 0);
    cfg_bypass = 1'b0;
    send(8, 10, 1'b0);
    wait_done(100);
    check("t6_err_range", 32'(err_range), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
